// File: rtl/arithmetic_execute_unit_pkg.sv
// Shared types and sizes for the integer execute unit: op encodings, ARM conditions, NZCV flags.
package arithmetic_execute_unit_pkg;

  localparam int unsigned GprSize    = 64;
  localparam int unsigned RobIdxSize = 4;
  localparam int unsigned ShamtW     = $clog2(GprSize);

  // Encodings 17..31 are undefined and produce a zero result.
  typedef enum logic [4:0] {
    OpPlus   = 5'd0,
    OpMinus  = 5'd1,
    OpAnd    = 5'd2,
    OpOr     = 5'd3,
    OpEor    = 5'd4,
    OpInv    = 5'd5,
    OpLsl    = 5'd6,
    OpLsr    = 5'd7,
    OpAsr    = 5'd8,
    OpMov    = 5'd9,
    OpPassA  = 5'd10,
    OpCsel   = 5'd11,
    OpCsinv  = 5'd12,
    OpCsinc  = 5'd13,
    OpCsneg  = 5'd14,
    OpCbz    = 5'd15,
    OpCbnz   = 5'd16
  } alu_op_t;

  typedef enum logic [3:0] {
    CondEq = 4'd0,
    CondNe = 4'd1,
    CondCs = 4'd2,
    CondCc = 4'd3,
    CondMi = 4'd4,
    CondPl = 4'd5,
    CondVs = 4'd6,
    CondVc = 4'd7,
    CondHi = 4'd8,
    CondLs = 4'd9,
    CondGe = 4'd10,
    CondLt = 4'd11,
    CondGt = 4'd12,
    CondLe = 4'd13,
    CondAl = 4'd14,
    CondNv = 4'd15
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/arithmetic_execute_unit_cond_eval.sv
// Combinational ARM condition-code evaluator over an NZCV flag set.
module arithmetic_execute_unit_cond_eval
  import arithmetic_execute_unit_pkg::*;
(
  input  cond_t cond,
  input  nzcv_t nzcv,
  output logic  cond_val
);

  logic hi;
  logic ge;

  assign hi = nzcv.c & ~nzcv.z;
  assign ge = (nzcv.n == nzcv.v);

  always_comb begin
    cond_val = 1'b1;
    unique case (cond)
      CondEq: cond_val = nzcv.z;
      CondNe: cond_val = ~nzcv.z;
      CondCs: cond_val = nzcv.c;
      CondCc: cond_val = ~nzcv.c;
      CondMi: cond_val = nzcv.n;
      CondPl: cond_val = ~nzcv.n;
      CondVs: cond_val = nzcv.v;
      CondVc: cond_val = ~nzcv.v;
      CondHi: cond_val = hi;
      CondLs: cond_val = ~hi;
      CondGe: cond_val = ge;
      CondLt: cond_val = ~ge;
      CondGt: cond_val = ~nzcv.z & ge;
      CondLe: cond_val = ~(~nzcv.z & ge);
      CondAl: cond_val = 1'b1;
      CondNv: cond_val = 1'b1;
    endcase
  end

endmodule

// File: rtl/arithmetic_execute_unit.sv
// Integer execute unit: combinational ALU/conditional-select datapath and one output register
// stage, giving a single-cycle-latency, always-ready pipeline toward the ROB/CDB.
module arithmetic_execute_unit
  import arithmetic_execute_unit_pkg::*;
(
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_fu_start,
  input  alu_op_t               in_alu_op,
  input  logic [GprSize-1:0]    in_val_a,
  input  logic [GprSize-1:0]    in_val_b,
  input  logic [5:0]            in_alu_val_hw,
  input  logic                  in_set_CC,
  input  cond_t                 in_cond,
  input  nzcv_t                 in_prev_nzcv,
  input  logic [RobIdxSize-1:0] in_dst_rob_idx,
  output logic                  out_fu_done,
  output logic [GprSize-1:0]    out_res,
  output nzcv_t                 out_nzcv,
  output logic                  out_set_nzcv,
  output logic                  out_cond_val,
  output logic [RobIdxSize-1:0] out_dst_rob_idx
);

  logic [GprSize:0]      add_full;
  logic [GprSize:0]      sub_full;
  logic [ShamtW-1:0]     shamt;
  logic                  cond_sel;
  logic [GprSize-1:0]    res_d;
  logic                  c_flag;
  logic                  v_flag;
  logic                  cond_val_d;
  nzcv_t                 nzcv_d;

  logic                  done_q;
  logic [GprSize-1:0]    res_q;
  nzcv_t                 nzcv_q;
  logic                  set_nzcv_q;
  logic                  cond_val_q;
  logic [RobIdxSize-1:0] rob_idx_q;

  // Subtraction as a + ~b + 1 so the carry-out reads as "no borrow".
  assign add_full = {1'b0, in_val_a} + {1'b0, in_val_b};
  assign sub_full = {1'b0, in_val_a} + {1'b0, ~in_val_b} + {{GprSize{1'b0}}, 1'b1};
  assign shamt    = in_val_b[ShamtW-1:0];

  arithmetic_execute_unit_cond_eval u_cond_eval (
    .cond     (in_cond),
    .nzcv     (in_prev_nzcv),
    .cond_val (cond_sel)
  );

  always_comb begin
    res_d  = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (in_alu_op)
      OpPlus: begin
        res_d  = add_full[GprSize-1:0];
        c_flag = add_full[GprSize];
        v_flag = (in_val_a[GprSize-1] == in_val_b[GprSize-1]) &&
                 (add_full[GprSize-1] != in_val_a[GprSize-1]);
      end
      OpMinus: begin
        res_d  = sub_full[GprSize-1:0];
        c_flag = sub_full[GprSize];
        v_flag = (in_val_a[GprSize-1] != in_val_b[GprSize-1]) &&
                 (sub_full[GprSize-1] != in_val_a[GprSize-1]);
      end
      OpAnd:   res_d = in_val_a & in_val_b;
      OpOr:    res_d = in_val_a | in_val_b;
      OpEor:   res_d = in_val_a ^ in_val_b;
      OpInv:   res_d = in_val_a | ~in_val_b;
      OpLsl:   res_d = in_val_a << shamt;
      OpLsr:   res_d = in_val_a >> shamt;
      OpAsr:   res_d = GprSize'($signed(in_val_a) >>> shamt);
      OpMov:   res_d = in_val_a | (in_val_b << in_alu_val_hw);
      OpPassA: res_d = in_val_a;
      OpCsel:  res_d = cond_sel ? in_val_a : in_val_b;
      OpCsinv: res_d = cond_sel ? in_val_a : ~in_val_b;
      OpCsinc: res_d = cond_sel ? in_val_a : in_val_b + 1'b1;
      OpCsneg: res_d = cond_sel ? in_val_a : '0 - in_val_b;
      OpCbz:   res_d = in_val_a;
      OpCbnz:  res_d = in_val_a;
      default: res_d = '0;
    endcase
  end

  always_comb begin
    cond_val_d = cond_sel;
    if (in_alu_op == OpCbz) begin
      cond_val_d = (in_val_a == '0);
    end else if (in_alu_op == OpCbnz) begin
      cond_val_d = (in_val_a != '0);
    end
  end

  always_comb begin
    nzcv_d = in_prev_nzcv;
    if (in_set_CC) begin
      nzcv_d = '{n: res_d[GprSize-1], z: (res_d == '0), c: c_flag, v: v_flag};
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      done_q     <= 1'b0;
      res_q      <= '0;
      nzcv_q     <= '0;
      set_nzcv_q <= 1'b0;
      cond_val_q <= 1'b0;
      rob_idx_q  <= '0;
    end else begin
      done_q <= in_fu_start;
      if (in_fu_start) begin
        res_q      <= res_d;
        nzcv_q     <= nzcv_d;
        set_nzcv_q <= in_set_CC;
        cond_val_q <= cond_val_d;
        rob_idx_q  <= in_dst_rob_idx;
      end
    end
  end

  assign out_fu_done     = done_q;
  assign out_res         = res_q;
  assign out_nzcv        = nzcv_q;
  assign out_set_nzcv    = set_nzcv_q;
  assign out_cond_val    = cond_val_q;
  assign out_dst_rob_idx = rob_idx_q;

endmodule

// File: tb/tb_arithmetic_execute_unit.sv
// Self-checking bench for arithmetic_execute_unit: directed cases plus randomized issue stream
// compared against an arithmetic reference model.
module tb_arithmetic_execute_unit;
  import arithmetic_execute_unit_pkg::*;

  logic        in_clk;
  logic        in_rst;
  logic        in_fu_start;
  alu_op_t     in_alu_op;
  logic [63:0] in_val_a;
  logic [63:0] in_val_b;
  logic [5:0]  in_alu_val_hw;
  logic        in_set_CC;
  cond_t       in_cond;
  nzcv_t       in_prev_nzcv;
  logic [3:0]  in_dst_rob_idx;
  logic        out_fu_done;
  logic [63:0] out_res;
  nzcv_t       out_nzcv;
  logic        out_set_nzcv;
  logic        out_cond_val;
  logic [3:0]  out_dst_rob_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic        exp_done;
  logic [63:0] exp_res;
  logic [3:0]  exp_nzcv;
  logic        exp_set;
  logic        exp_cond;
  logic [3:0]  exp_rob;

  arithmetic_execute_unit dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_fu_start     (in_fu_start),
    .in_alu_op       (in_alu_op),
    .in_val_a        (in_val_a),
    .in_val_b        (in_val_b),
    .in_alu_val_hw   (in_alu_val_hw),
    .in_set_CC       (in_set_CC),
    .in_cond         (in_cond),
    .in_prev_nzcv    (in_prev_nzcv),
    .in_dst_rob_idx  (in_dst_rob_idx),
    .out_fu_done     (out_fu_done),
    .out_res         (out_res),
    .out_nzcv        (out_nzcv),
    .out_set_nzcv    (out_set_nzcv),
    .out_cond_val    (out_cond_val),
    .out_dst_rob_idx (out_dst_rob_idx)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic eval_cond(input cond_t cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      CondEq:  return z;
      CondNe:  return !z;
      CondCs:  return c;
      CondCc:  return !c;
      CondMi:  return n;
      CondPl:  return !n;
      CondVs:  return v;
      CondVc:  return !v;
      CondHi:  return c && !z;
      CondLs:  return !(c && !z);
      CondGe:  return n == v;
      CondLt:  return n != v;
      CondGt:  return !z && (n == v);
      CondLe:  return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Flags from true-precision arithmetic: unsigned carry and signed range overflow.
  function automatic void model(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                input logic [5:0] hw, input logic setcc, input cond_t cond,
                                input logic [3:0] prev, output logic [63:0] res,
                                output logic [3:0] nzcv, output logic cv);
    logic               c;
    logic               cf;
    logic               vf;
    int                 sh;
    logic [64:0]        wide;
    logic signed [127:0] sa, sb, st, smax, smin;
    c  = eval_cond(cond, prev);
    sh = int'(b[5:0]);
    cf = 1'b0;
    vf = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    smax = (128'sd1 <<< 63) - 128'sd1;
    smin = -(128'sd1 <<< 63);
    case (op)
      OpPlus: begin
        wide = 65'(a) + 65'(b);
        res  = wide[63:0];
        cf   = wide[64];
        st   = sa + sb;
        vf   = (st > smax) || (st < smin);
      end
      OpMinus: begin
        res = a - b;
        cf  = (a >= b);
        st  = sa - sb;
        vf  = (st > smax) || (st < smin);
      end
      OpAnd:   res = a & b;
      OpOr:    res = a | b;
      OpEor:   res = a ^ b;
      OpInv:   res = a | ~b;
      OpLsl:   res = a << sh;
      OpLsr:   res = a >> sh;
      OpAsr:   res = (a >> sh) | (a[63] ? ~(~64'd0 >> sh) : 64'd0);
      OpMov:   res = a | (b << hw);
      OpPassA: res = a;
      OpCsel:  res = c ? a : b;
      OpCsinv: res = c ? a : ~b;
      OpCsinc: res = c ? a : b + 64'd1;
      OpCsneg: res = c ? a : 64'd0 - b;
      OpCbz:   res = a;
      OpCbnz:  res = a;
      default: res = 64'd0;
    endcase
    if (op == OpCbz) cv = (a == 64'd0);
    else if (op == OpCbnz) cv = (a != 64'd0);
    else cv = c;
    nzcv = setcc ? {res[63], res == 64'd0, cf, vf} : prev;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_done"}, {63'd0, out_fu_done}, {63'd0, exp_done});
    check({tag, "_res"}, out_res, exp_res);
    check({tag, "_nzcv"}, {60'd0, out_nzcv}, {60'd0, exp_nzcv});
    check({tag, "_set"}, {63'd0, out_set_nzcv}, {63'd0, exp_set});
    check({tag, "_cond"}, {63'd0, out_cond_val}, {63'd0, exp_cond});
    check({tag, "_rob"}, {60'd0, out_dst_rob_idx}, {60'd0, exp_rob});
  endtask

  // Drive one cycle on the falling edge, update the model, check #1 after the rising edge.
  task automatic apply(input string tag, input logic start, input alu_op_t op,
                       input logic [63:0] a, input logic [63:0] b, input logic [5:0] hw,
                       input logic setcc, input cond_t cond, input logic [3:0] prev,
                       input logic [3:0] rob);
    logic [63:0] r;
    logic [3:0]  f;
    logic        cv;
    @(negedge in_clk);
    in_fu_start    = start;
    in_alu_op      = op;
    in_val_a       = a;
    in_val_b       = b;
    in_alu_val_hw  = hw;
    in_set_CC      = setcc;
    in_cond        = cond;
    in_prev_nzcv   = nzcv_t'(prev);
    in_dst_rob_idx = rob;
    model(op, a, b, hw, setcc, cond, prev, r, f, cv);
    exp_done = start;
    if (start) begin
      exp_res  = r;
      exp_nzcv = f;
      exp_set  = setcc;
      exp_cond = cv;
      exp_rob  = rob;
    end
    @(posedge in_clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return ~64'd0;
      4:       return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    in_rst         = 1'b0;
    in_fu_start    = 1'b0;
    in_alu_op      = OpPlus;
    in_val_a       = '0;
    in_val_b       = '0;
    in_alu_val_hw  = '0;
    in_set_CC      = 1'b0;
    in_cond        = CondEq;
    in_prev_nzcv   = '0;
    in_dst_rob_idx = '0;
    exp_done = 1'b0;
    exp_res  = '0;
    exp_nzcv = '0;
    exp_set  = 1'b0;
    exp_cond = 1'b0;
    exp_rob  = '0;

    repeat (2) @(posedge in_clk);
    #1;
    check_all("reset");
    @(negedge in_clk);
    in_rst = 1'b1;

    apply("plus_fff", 1'b1, OpPlus, 64'd0, 64'hFFF, 6'd0, 1'b1, CondAl, 4'b0000, 4'd1);
    check("plus_fff_const", {out_res[59:0], out_nzcv}, {60'hFFF, 4'b0000});
    apply("minus_eq", 1'b1, OpMinus, 64'd5, 64'd5, 6'd0, 1'b1, CondAl, 4'b0000, 4'd2);
    check("minus_eq_const", {out_res[59:0], out_nzcv}, {60'd0, 4'b0110});
    apply("plus_ovf", 1'b1, OpPlus, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, CondAl,
          4'b0000, 4'd3);
    check("plus_ovf_res", out_res, 64'h8000_0000_0000_0000);
    check("plus_ovf_nzcv", {60'd0, out_nzcv}, 64'b1001);
    apply("mov_hw16", 1'b1, OpMov, 64'd0, 64'h1234, 6'd16, 1'b0, CondAl, 4'b1010, 4'd4);
    check("mov_hw16_res", out_res, 64'h1234_0000);
    apply("csinc_ne", 1'b1, OpCsinc, 64'd7, 64'd9, 6'd0, 1'b0, CondEq, 4'b0000, 4'd5);
    check("csinc_ne_res", {out_res[62:0], out_cond_val}, {63'd10, 1'b0});
    apply("csinc_eq", 1'b1, OpCsinc, 64'd7, 64'd9, 6'd0, 1'b0, CondEq, 4'b0100, 4'd6);
    check("csinc_eq_res", out_res, 64'd7);
    apply("undef_op", 1'b1, alu_op_t'(5'd23), 64'd99, 64'd1, 6'd0, 1'b1, CondAl, 4'b0000,
          4'd7);
    apply("asr_neg", 1'b1, OpAsr, 64'h8000_0000_0000_0000, 64'hFFC4, 6'd0, 1'b0, CondAl,
          4'b0000, 4'd8);

    // Back-to-back issue, then idle: done must track start with a one-cycle lag.
    for (int i = 0; i < 4; i++) begin
      apply("b2b", 1'b1, OpEor, rand_val(), rand_val(), 6'd0, 1'b1, CondAl, 4'b0000,
            4'(i + 9));
    end
    apply("idle0", 1'b0, OpPlus, 64'd1, 64'd1, 6'd0, 1'b1, CondAl, 4'b0000, 4'd0);
    apply("idle1", 1'b0, OpMinus, 64'd3, 64'd1, 6'd0, 1'b0, CondAl, 4'b1111, 4'd0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] hw;
      hw = 6'(16 * $urandom_range(0, 3));
      apply("rand", ($urandom_range(0, 3) != 0), alu_op_t'(5'($urandom_range(0, 20))),
            rand_val(), rand_val(), hw, 1'($urandom), cond_t'(4'($urandom)), 4'($urandom),
            4'($urandom));
    end

    // Reset asserted mid-operation must clear outputs before the next clock edge.
    apply("pre_rst", 1'b1, OpPassA, 64'hDEAD_BEEF, 64'd0, 6'd0, 1'b1, CondAl, 4'b0000, 4'd9);
    #2;
    in_rst = 1'b0;
    #1;
    exp_done = 1'b0;
    exp_res  = '0;
    exp_nzcv = '0;
    exp_set  = 1'b0;
    exp_cond = 1'b0;
    exp_rob  = '0;
    check_all("async_rst");
    @(negedge in_clk);
    in_rst = 1'b1;
    apply("post_rst", 1'b1, OpMinus, 64'd1, 64'd2, 6'd0, 1'b1, CondAl, 4'b0000, 4'd15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
